// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the packed-BCD up/down counter.
// Helpers work on a 32-bit (8-decade) container; ndig selects how many decades are live.
package bcd_cnt_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int         MAX_DIGITS    = 8;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_REJECT,
        OP_STEP
    } op_e;

    function automatic logic [31:0] bcd_to_bin(input logic [31:0] v, input int ndig);
        logic [31:0] acc;
        acc = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < ndig) begin
                acc = acc * 32'd10 + 32'(v[i*4 +: 4]);
            end
        end
        return acc;
    endfunction

    function automatic logic is_valid_bcd(input logic [31:0] v, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < ndig) && (v[i*4 +: 4] > BCD_MAX_DIGIT)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and result bundle of the BCD up/down counter.
// The master drives the count controls; the slave (the counter) returns both count views.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = $clog2(10**DIGITS)
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tc;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  bin, bcd, tc, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output bin, bcd, tc, load_err
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD decade: computes the next nibble for a step in either direction.
// step_out ripples to the next decade when this one wraps (9->0 up, 0->9 down).
module bcd_digit_cell
    import bcd_cnt_pkg::*;
(
    input  logic [3:0] nibble_q,
    input  logic       up,
    input  logic       step_in,
    output logic [3:0] nibble_d,
    output logic       step_out,
    output logic       at_limit
);

    assign at_limit = up ? (nibble_q == BCD_MAX_DIGIT) : (nibble_q == 4'd0);
    assign step_out = step_in & at_limit;

    always_comb begin
        nibble_d = nibble_q;
        if (step_in) begin
            if (at_limit) begin
                nibble_d = up ? 4'd0 : BCD_MAX_DIGIT;
            end else begin
                nibble_d = up ? (nibble_q + 4'd1) : (nibble_q - 4'd1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade decimal counter keeping binary and packed-BCD views in lock-step.
// Supports load with BCD validation, up/down stepping, and wrap or saturate at the limits.
module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = $clog2(10**DIGITS),
    parameter int SAT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_updown_counter_if.slave    bus
);

    localparam logic [BIN_W-1:0] CNT_MAX = BIN_W'(10**DIGITS - 1);
    localparam bit               SAT_ON  = (SAT != 0);

    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_step;
    logic                tc_q, tc_d;
    logic                err_q, err_d;

    logic [DIGITS:0]     carry;
    logic [DIGITS-1:0]   at_limit;
    logic                all_limit;
    logic                sat_hold;
    op_e                 op;

    always_comb begin
        op = OP_IDLE;
        if (bus.load) begin
            op = is_valid_bcd(32'(bus.load_val), DIGITS) ? OP_LOAD : OP_REJECT;
        end else if (bus.en) begin
            op = OP_STEP;
        end
    end

    // A saturating step at the limit leaves the decades untouched but still flags tc.
    assign all_limit = &at_limit;
    assign sat_hold  = SAT_ON && (op == OP_STEP) && all_limit;
    assign carry[0]  = (op == OP_STEP) && !sat_hold;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_digit (
            .nibble_q (bcd_q[g*4 +: 4]),
            .up       (bus.up),
            .step_in  (carry[g]),
            .nibble_d (bcd_step[g*4 +: 4]),
            .step_out (carry[g+1]),
            .at_limit (at_limit[g])
        );
    end

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        case (op)
            OP_LOAD: begin
                bcd_d = bus.load_val;
                bin_d = BIN_W'(bcd_to_bin(32'(bus.load_val), DIGITS));
            end
            OP_REJECT: begin
                err_d = 1'b1;
            end
            OP_STEP: begin
                bcd_d = bcd_step;
                tc_d  = carry[DIGITS] | sat_hold;
                if (carry[DIGITS]) begin
                    bin_d = bus.up ? '0 : CNT_MAX;
                end else if (carry[0]) begin
                    bin_d = bus.up ? (bin_q + BIN_W'(1)) : (bin_q - BIN_W'(1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign bus.bin      = bin_q;
    assign bus.bcd      = bcd_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = err_q;

endmodule
